// File: rtl/serial_link_pkg.sv
// Shared parameters and types for the serial link virtual-channel credit logic.
package serial_link_pkg;

  localparam int NumVc           = 4;
  localparam int NumCredits      = 16;
  localparam int ReturnThreshold = 4;
  localparam int FlushCycles     = 64;

  localparam int VcIdxW  = (NumVc > 1) ? $clog2(NumVc) : 1;
  localparam int CreditW = $clog2(NumCredits + 1);
  // One extra bit so credit sums can exceed NumCredits before saturation.
  localparam int SumW    = CreditW + 1;
  localparam int FlushW  = $clog2(FlushCycles + 1);

  typedef logic [VcIdxW-1:0]  vc_idx_t;
  typedef logic [CreditW-1:0] credit_t;
  typedef logic [SumW-1:0]    credit_sum_t;
  typedef logic [FlushW-1:0]  flush_cnt_t;

  // Round-robin successor, wrapping at NumVc even when it is not a power of two.
  function automatic vc_idx_t next_vc(input vc_idx_t v);
    if (int'(v) == NumVc - 1) return '0;
    else return v + vc_idx_t'(1);
  endfunction

endpackage

// File: rtl/serial_link_rr_lock.sv
// Round-robin picker over NumVc requesters. Once the grant is offered without
// acceptance it is locked to that requester until the handshake completes.
module serial_link_rr_lock
  import serial_link_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumVc-1:0] req,
  input  logic             ready,
  output logic             valid,
  output vc_idx_t          idx,
  output logic [NumVc-1:0] grant
);

  vc_idx_t ptr;
  vc_idx_t lock_idx;
  logic    locked;
  vc_idx_t pick;
  logic    any;

  // Pick the first requester at or after the pointer; a held lock overrides it.
  always_comb begin
    int j;
    j     = 0;
    any   = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NumVc; i++) begin
      j = (int'(ptr) + i) % NumVc;
      if (!any && req[j]) begin
        any  = 1'b1;
        pick = vc_idx_t'(j);
      end
    end
    valid = locked | any;
    idx   = locked ? lock_idx : pick;
    grant = '0;
    if (valid) grant[idx] = 1'b1;
  end

  // Advance the pointer past the winner on handshake; lock a stalled offer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr      <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else if (valid && ready) begin
      ptr    <= next_vc(idx);
      locked <= 1'b0;
    end else if (valid && !locked) begin
      locked   <= 1'b1;
      lock_idx <= pick;
    end
  end

endmodule

// File: rtl/serial_link_vc_credit_ctrl.sv
// Per-VC credit flow control: sender arbitration with credit consumption and
// receiver-side batching of freed buffer slots back to the peer.
module serial_link_vc_credit_ctrl
  import serial_link_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumVc-1:0]        data_valid_i,
  output logic [NumVc-1:0]        data_ready_o,
  output logic                    link_valid_o,
  output vc_idx_t                 link_vc_o,
  input  logic                    link_ready_i,
  input  logic                    credit_rcv_valid_i,
  input  vc_idx_t                 credit_rcv_vc_i,
  input  credit_t                 credit_rcv_num_i,
  input  logic [NumVc-1:0]        buf_free_i,
  output logic                    credit_snd_valid_o,
  output vc_idx_t                 credit_snd_vc_o,
  output credit_t                 credit_snd_num_o,
  input  logic                    credit_snd_ready_i,
  output credit_t [NumVc-1:0]     credits_avail_o,
  output logic                    overflow_o
);

  credit_t [NumVc-1:0] avail, avail_nxt;
  credit_t [NumVc-1:0] pending, pend_nxt;
  flush_cnt_t          flush_cnt;
  logic                overflow, ovf_nxt;
  logic [NumVc-1:0]    snd_elig, ret_elig, snd_grant, ret_grant;
  logic                snd_hs, ret_hs;
  credit_sum_t         a_sum, p_sum;

  serial_link_rr_lock u_snd_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req   (snd_elig),
    .ready (link_ready_i),
    .valid (link_valid_o),
    .idx   (link_vc_o),
    .grant (snd_grant)
  );

  serial_link_rr_lock u_ret_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req   (ret_elig),
    .ready (credit_snd_ready_i),
    .valid (credit_snd_valid_o),
    .idx   (credit_snd_vc_o),
    .grant (ret_grant)
  );

  assign snd_hs           = link_valid_o & link_ready_i;
  assign ret_hs           = credit_snd_valid_o & credit_snd_ready_i;
  assign data_ready_o     = snd_grant & {NumVc{snd_hs}};
  // Live count: slots freed while the return is stalled ride along with it.
  assign credit_snd_num_o = pending[credit_snd_vc_o];
  assign credits_avail_o  = avail;
  assign overflow_o       = overflow;

  // A VC without credits never requests, so it cannot block the others.
  always_comb begin
    for (int v = 0; v < NumVc; v++) begin
      snd_elig[v] = data_valid_i[v] && (avail[v] != '0);
      ret_elig[v] = (pending[v] >= credit_t'(ReturnThreshold)) ||
                    ((flush_cnt == flush_cnt_t'(FlushCycles)) && (pending[v] != '0));
    end
  end

  // Next credit and pending counts, saturating at NumCredits with overflow flagged.
  always_comb begin
    avail_nxt = avail;
    pend_nxt  = pending;
    ovf_nxt   = overflow;
    a_sum     = '0;
    p_sum     = '0;
    for (int v = 0; v < NumVc; v++) begin
      a_sum = {1'b0, avail[v]};
      if (snd_hs && snd_grant[v]) a_sum = a_sum - credit_sum_t'(1);
      if (credit_rcv_valid_i && (credit_rcv_vc_i == vc_idx_t'(v)))
        a_sum = a_sum + {1'b0, credit_rcv_num_i};
      if (a_sum > credit_sum_t'(NumCredits)) begin
        avail_nxt[v] = credit_t'(NumCredits);
        ovf_nxt      = 1'b1;
      end else begin
        avail_nxt[v] = a_sum[CreditW-1:0];
      end

      p_sum = {1'b0, pending[v]};
      if (ret_hs && ret_grant[v]) p_sum = p_sum - {1'b0, credit_snd_num_o};
      if (buf_free_i[v]) p_sum = p_sum + credit_sum_t'(1);
      if (p_sum > credit_sum_t'(NumCredits)) begin
        pend_nxt[v] = credit_t'(NumCredits);
        ovf_nxt     = 1'b1;
      end else begin
        pend_nxt[v] = p_sum[CreditW-1:0];
      end
    end
  end

  // Counter state, sticky overflow, and idle-time flush counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NumVc; v++) avail[v] <= credit_t'(NumCredits);
      pending   <= '0;
      overflow  <= 1'b0;
      flush_cnt <= '0;
    end else begin
      avail    <= avail_nxt;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
      if (ret_hs)
        flush_cnt <= '0;
      else if (flush_cnt != flush_cnt_t'(FlushCycles))
        flush_cnt <= flush_cnt + flush_cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_serial_link_vc_credit_ctrl.sv
// Directed bench for serial_link_vc_credit_ctrl: a vector table for arbitration
// and credit accounting plus hand-written multi-cycle sequences.
module tb_serial_link_vc_credit_ctrl;
  import serial_link_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NumVc-1:0]    data_valid_i;
  logic [NumVc-1:0]    data_ready_o;
  logic                link_valid_o;
  vc_idx_t             link_vc_o;
  logic                link_ready_i;
  logic                credit_rcv_valid_i;
  vc_idx_t             credit_rcv_vc_i;
  credit_t             credit_rcv_num_i;
  logic [NumVc-1:0]    buf_free_i;
  logic                credit_snd_valid_o;
  vc_idx_t             credit_snd_vc_o;
  credit_t             credit_snd_num_o;
  logic                credit_snd_ready_i;
  credit_t [NumVc-1:0] credits_avail_o;
  logic                overflow_o;

  serial_link_vc_credit_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .data_valid_i      (data_valid_i),
    .data_ready_o      (data_ready_o),
    .link_valid_o      (link_valid_o),
    .link_vc_o         (link_vc_o),
    .link_ready_i      (link_ready_i),
    .credit_rcv_valid_i(credit_rcv_valid_i),
    .credit_rcv_vc_i   (credit_rcv_vc_i),
    .credit_rcv_num_i  (credit_rcv_num_i),
    .buf_free_i        (buf_free_i),
    .credit_snd_valid_o(credit_snd_valid_o),
    .credit_snd_vc_o   (credit_snd_vc_o),
    .credit_snd_num_o  (credit_snd_num_o),
    .credit_snd_ready_i(credit_snd_ready_i),
    .credits_avail_o   (credits_avail_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  dv;
    logic        lr;
    logic        rv;
    logic [1:0]  rvc;
    logic [4:0]  rnum;
    logic        exp_lv;
    logic [1:0]  exp_vc;
    logic [3:0]  exp_dr;
    logic [19:0] exp_av;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [3:0] dv, input logic lr, input logic rv,
                              input logic [1:0] rvc, input logic [4:0] rnum,
                              input logic lv, input logic [1:0] vc, input logic [3:0] dr,
                              input logic [4:0] a3, input logic [4:0] a2,
                              input logic [4:0] a1, input logic [4:0] a0);
    vec_t r;
    r.dv = dv; r.lr = lr; r.rv = rv; r.rvc = rvc; r.rnum = rnum;
    r.exp_lv = lv; r.exp_vc = vc; r.exp_dr = dr;
    r.exp_av = {a3, a2, a1, a0};
    r.exp_ovf = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    data_valid_i       = '0;
    link_ready_i       = 1'b0;
    credit_rcv_valid_i = 1'b0;
    credit_rcv_vc_i    = '0;
    credit_rcv_num_i   = '0;
    buf_free_i         = '0;
    credit_snd_ready_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int count;
    int n;

    // Arbitration and credit accounting, starting from reset.
    tbl[0]  = mk(4'hf, 1, 0, 0, 0, 1, 0, 4'h1, 16, 16, 16, 16);
    tbl[1]  = mk(4'hf, 1, 0, 0, 0, 1, 1, 4'h2, 16, 16, 16, 15);
    tbl[2]  = mk(4'hf, 1, 0, 0, 0, 1, 2, 4'h4, 16, 16, 15, 15);
    tbl[3]  = mk(4'hf, 1, 0, 0, 0, 1, 3, 4'h8, 16, 15, 15, 15);
    tbl[4]  = mk(4'hf, 1, 0, 0, 0, 1, 0, 4'h1, 15, 15, 15, 15);
    tbl[5]  = mk(4'hf, 0, 0, 0, 0, 1, 1, 4'h0, 15, 15, 15, 14);
    tbl[6]  = mk(4'hf, 0, 0, 0, 0, 1, 1, 4'h0, 15, 15, 15, 14);
    tbl[7]  = mk(4'hd, 0, 0, 0, 0, 1, 1, 4'h0, 15, 15, 15, 14);
    tbl[8]  = mk(4'hf, 0, 0, 0, 0, 1, 1, 4'h0, 15, 15, 15, 14);
    tbl[9]  = mk(4'hf, 0, 0, 0, 0, 1, 1, 4'h0, 15, 15, 15, 14);
    tbl[10] = mk(4'hf, 1, 0, 0, 0, 1, 1, 4'h2, 15, 15, 15, 14);
    tbl[11] = mk(4'h1, 1, 0, 0, 0, 1, 0, 4'h1, 15, 15, 14, 14);
    tbl[12] = mk(4'h0, 0, 1, 1, 2, 0, 0, 4'h0, 15, 15, 14, 13);
    tbl[13] = mk(4'h0, 0, 1, 0, 0, 0, 0, 4'h0, 15, 15, 16, 13);
    tbl[14] = mk(4'h1, 1, 1, 0, 1, 1, 0, 4'h1, 15, 15, 16, 13);
    tbl[15] = mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 15, 15, 16, 13);
    tbl[16] = mk(4'h4, 1, 1, 3, 1, 1, 2, 4'h4, 15, 15, 16, 13);
    tbl[17] = mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 16, 14, 16, 13);

    idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("reset_avail", 32'(credits_avail_o), {12'h0, 5'd16, 5'd16, 5'd16, 5'd16});
    chk("reset_ovf", 32'(overflow_o), 0);
    chk("reset_link_valid", 32'(link_valid_o), 0);
    chk("reset_data_ready", 32'(data_ready_o), 0);
    chk("reset_snd_valid", 32'(credit_snd_valid_o), 0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      data_valid_i       = tbl[i].dv;
      link_ready_i       = tbl[i].lr;
      credit_rcv_valid_i = tbl[i].rv;
      credit_rcv_vc_i    = tbl[i].rvc;
      credit_rcv_num_i   = tbl[i].rnum;
      @(negedge clk_i);
      chk($sformatf("vec%0d_link_valid", i), 32'(link_valid_o), 32'(tbl[i].exp_lv));
      if (tbl[i].exp_lv) chk($sformatf("vec%0d_link_vc", i), 32'(link_vc_o), 32'(tbl[i].exp_vc));
      chk($sformatf("vec%0d_data_ready", i), 32'(data_ready_o), 32'(tbl[i].exp_dr));
      chk($sformatf("vec%0d_avail", i), 32'(credits_avail_o), 32'(tbl[i].exp_av));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].exp_ovf));
      step();
    end
    idle();

    // VC0 alone drains exactly its 16 credits.
    do_reset();
    data_valid_i = 4'h1;
    link_ready_i = 1'b1;
    count = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (link_valid_o && data_ready_o[0]) count++;
      step();
    end
    @(negedge clk_i);
    chk("drain_count", 32'(count), 16);
    chk("drain_link_valid", 32'(link_valid_o), 0);
    chk("drain_avail", 32'(credits_avail_o), {12'h0, 5'd16, 5'd16, 5'd16, 5'd0});
    idle();

    // Starved VC2 becomes eligible the cycle after credits come back.
    do_reset();
    data_valid_i = 4'h4;
    link_ready_i = 1'b1;
    repeat (16) step();
    credit_rcv_valid_i = 1'b1;
    credit_rcv_vc_i    = 2'd2;
    credit_rcv_num_i   = 5'd3;
    @(negedge clk_i);
    chk("starve_link_valid", 32'(link_valid_o), 0);
    chk("starve_avail2", 32'(credits_avail_o[2]), 0);
    step();
    credit_rcv_valid_i = 1'b0;
    @(negedge clk_i);
    chk("refill_link_valid", 32'(link_valid_o), 1);
    chk("refill_link_vc", 32'(link_vc_o), 2);
    chk("refill_avail2", 32'(credits_avail_o[2]), 3);
    step();
    @(negedge clk_i);
    chk("refill_after_hs_avail2", 32'(credits_avail_o[2]), 2);
    idle();

    // Threshold return on VC1, growing while stalled.
    do_reset();
    buf_free_i = 4'h2;
    repeat (4) step();
    buf_free_i = 4'h0;
    @(negedge clk_i);
    chk("ret_valid", 32'(credit_snd_valid_o), 1);
    chk("ret_vc", 32'(credit_snd_vc_o), 1);
    chk("ret_num4", 32'(credit_snd_num_o), 4);
    step();
    buf_free_i = 4'h2;
    repeat (2) step();
    buf_free_i = 4'h0;
    credit_snd_ready_i = 1'b1;
    @(negedge clk_i);
    chk("ret_stall_vc", 32'(credit_snd_vc_o), 1);
    chk("ret_num6", 32'(credit_snd_num_o), 6);
    step();
    credit_snd_ready_i = 1'b0;
    @(negedge clk_i);
    chk("ret_after_hs_valid", 32'(credit_snd_valid_o), 0);
    chk("ret_after_hs_num1", 32'(dut.pending[1]), 0);
    idle();

    // Single freed slot on VC3 is flushed after the idle timeout.
    do_reset();
    buf_free_i = 4'h8;
    step();
    buf_free_i = 4'h0;
    n = 1;
    while (!credit_snd_valid_o && n < 200) begin
      step();
      n++;
    end
    chk("flush_delay", 32'(n), 64);
    chk("flush_vc", 32'(credit_snd_vc_o), 3);
    chk("flush_num", 32'(credit_snd_num_o), 1);
    credit_snd_ready_i = 1'b1;
    step();
    credit_snd_ready_i = 1'b0;
    @(negedge clk_i);
    chk("flush_after_hs_valid", 32'(credit_snd_valid_o), 0);
    idle();

    // Over-return saturates and sets sticky overflow until reset.
    do_reset();
    data_valid_i = 4'h1;
    link_ready_i = 1'b1;
    repeat (2) step();
    idle();
    @(negedge clk_i);
    chk("ovf_pre_avail0", 32'(credits_avail_o[0]), 14);
    credit_rcv_valid_i = 1'b1;
    credit_rcv_vc_i    = 2'd0;
    credit_rcv_num_i   = 5'd5;
    step();
    credit_rcv_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ovf_avail0", 32'(credits_avail_o[0]), 16);
    chk("ovf_set", 32'(overflow_o), 1);
    repeat (10) step();
    chk("ovf_sticky", 32'(overflow_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", 32'(overflow_o), 0);
    step();
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_link_vc_credit_ctrl.md
Name: serial_link_vc_credit_ctrl

Overview:
- Per-virtual-channel credit-based flow control between the serial link data path and the PHY, generalising the single credit pool to NumVc independent channels.
- Sender side: arbitrates among VCs that hold credits and consumes one credit per transmitted flit.
- Receiver side: accumulates locally freed buffer slots and returns them to the peer in batches.
- Sits between the link layer and the channel allocator.

Parameters:
- NumVc, 4, number of virtual channels (>=1).
- NumCredits, 16, credits per VC at reset; equals peer receive FIFO depth.
- ReturnThreshold, 4, pending credits needed to trigger a return (1..NumCredits).
- FlushCycles, 64, idle cycles after which any nonzero pending count is returned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_valid_i  in  NumVc  per-VC flit request
- data_ready_o  out  NumVc  per-VC accept
- link_valid_o  out  1  flit to PHY valid
- link_vc_o  out  vc_idx_t  VC of flit
- link_ready_i  in  1  PHY accepts flit
- credit_rcv_valid_i  in  1  peer credit return strobe
- credit_rcv_vc_i  in  vc_idx_t  VC of returned credits
- credit_rcv_num_i  in  credit_t  number returned
- buf_free_i  in  NumVc  local receive slot freed, one credit per pulse
- credit_snd_valid_o  out  1  credit return to peer valid
- credit_snd_vc_o  out  vc_idx_t  VC
- credit_snd_num_o  out  credit_t  credits returned
- credit_snd_ready_i  in  1  return accepted
- credits_avail_o  out  NumVc x credit_t  current sender credits
- overflow_o  out  1  sticky credit overflow error

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - avail[v] = NumCredits; pending[v] = 0; flush counter 0.
  - Both arbiter pointers at VC0; overflow_o = 0.
  - All valid outputs 0; data_ready_o = 0.
  - Reset mid-transfer discards locks and counts.
- Sender arbitration:
  - Eligible[v] = data_valid_i[v] & (avail[v] != 0).
  - Round-robin, starting at the pointer.
  - link_valid_o = any eligible, combinational (zero latency).
  - Once link_valid_o is high without link_ready_i, the grant is locked: link_vc_o is stable until the handshake, and the locked VC already owns a credit.
  - data_ready_o[v] = link_ready_i & grant[v] & link_valid_o.
  - On handshake, the pointer moves to winner+1 (mod NumVc).
- Credit accounting, per VC per cycle:
  - avail_next = avail - consume + (rcv_valid & rcv_vc==v ? rcv_num : 0).
  - Simultaneous consume and return on the same VC nets out.
  - If the sum exceeds NumCredits: saturate to NumCredits and set overflow_o (sticky until reset).
  - rcv_num = 0 is a no-op.
- Receiver return:
  - pending[v] += buf_free_i[v]; saturates at NumCredits with overflow_o set.
  - Return-eligible[v] = pending[v] >= ReturnThreshold, or (flush counter == FlushCycles and pending[v] != 0).
  - Flush counter increments while no credit_snd handshake occurs; it clears on a handshake and saturates at FlushCycles.
  - Separate round-robin arbitration with the same lock rule.
  - credit_snd_num_o = live pending[locked VC]; it may grow while stalled, and the value on the handshake cycle is the one sent.
  - On handshake: pending = pending - num_o + buf_free_i same cycle.
- credits_avail_o is the registered avail array; there is no combinational path from the rcv inputs.
- A VC with data_valid_i high and avail = 0 is never granted and never stalls other VCs.

Decomposition:
- serial_link_pkg additions:
  - NumVc
  - vc_idx_t = logic [$clog2(NumVc)-1:0], 1 bit minimum
  - existing credit_t width $clog2(NumCredits+1)
- Sub-module serial_link_rr_lock: NumVc-wide round-robin picker with grant lock until handshake. It is instantiated twice, once for sender and once for credit return.

Test Plan:
- Reset, then VC0 valid continuously with link_ready_i=1 and no returns: exactly 16 flits accepted, then link_valid_o=0; credits_avail_o[0]=0, other VCs 16.
- VC0..3 all valid, ready=1: grants in order 0,1,2,3,0,…; with ready held 0 for 5 cycles, link_vc_o stays constant.
- avail[2]=0 and VC2 valid, return 3 credits on VC2 in the same cycle VC2 is otherwise eligible: VC2 granted next cycle, avail[2]=2 after its handshake.
- 4 buf_free_i pulses on VC1: credit_snd_valid_o with vc=1, num=4. Hold ready low for 2 cycles while 2 more pulses arrive: num=6 sent, pending[1]=0 after.
- 1 buf_free_i pulse on VC3 then idle: credit_snd_valid_o rises after 64 cycles with num=1.
- Return 5 credits to a VC with avail=14: avail saturates at 16, overflow_o=1 and stays 1 until rst_ni asserted.
